// File: rtl/rggen_register_initiator.sv
// Register-bus initiator: accepts one command, drives it to the attached registers, returns one response.
// Optional busy timeout is enabled by defining RGGEN_INITIATOR_TIMEOUT_EN.
module rggen_register_initiator #(
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned REGISTERS      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic                           i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_cmd_address,
    input  logic [BUS_WIDTH-1:0]           i_cmd_write_data,
    input  logic [BUS_WIDTH-1:0]           i_cmd_strobe,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [1:0]                     o_rsp_status,
    output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
    output logic                           o_reg_valid,
    output logic [1:0]                     o_reg_access,
    output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
    output logic [BUS_WIDTH-1:0]           o_reg_write_data,
    output logic [BUS_WIDTH-1:0]           o_reg_strobe,
    input  logic [REGISTERS-1:0]           i_reg_active,
    input  logic [REGISTERS-1:0]           i_reg_ready,
    input  logic [2*REGISTERS-1:0]         i_reg_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_BUSY    = 2'd1;
    localparam logic [1:0] STATE_RESPOND = 2'd2;

    localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

    // Elaboration-time parameter sanity checks.
    if ((BUS_WIDTH % 8) != 0 || REGISTERS < 1 || ADDRESS_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rggen_register_initiator: illegal parameter combination");
    end

    logic [1:0]               state_q, state_d;
    logic                     req_write_q, req_write_d;
    logic [ADDRESS_WIDTH-1:0] req_address_q, req_address_d;
    logic [BUS_WIDTH-1:0]     req_write_data_q, req_write_data_d;
    logic [BUS_WIDTH-1:0]     req_strobe_q, req_strobe_d;
    logic [1:0]               rsp_status_q, rsp_status_d;
    logic [BUS_WIDTH-1:0]     rsp_read_data_q, rsp_read_data_d;

    logic [REGISTERS-1:0]     hit;
    logic [1:0]               sel_status;
    logic [BUS_WIDTH-1:0]     sel_read_data;
    logic                     completed;
    logic                     decode_error;
    logic                     timed_out;

    // OR-combine status/data of every register that is both active and ready.
    always_comb begin : select_response
        hit           = i_reg_active & i_reg_ready;
        sel_status    = '0;
        sel_read_data = '0;
        for (int k = 0; k < int'(REGISTERS); k++) begin
            if (hit[k]) begin
                sel_status    = sel_status | i_reg_status[2*k +: 2];
                sel_read_data = sel_read_data | i_reg_read_data[BUS_WIDTH*k +: BUS_WIDTH];
            end
        end
        completed    = |hit;
        decode_error = (i_reg_active == '0);
    end

`ifdef RGGEN_INITIATOR_TIMEOUT_EN
    localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [COUNT_WIDTH-1:0] timeout_count_q, timeout_count_d;

    // Held at zero while idle so each BUSY phase starts counting from zero.
    always_comb begin : timeout_next
        timeout_count_d = timeout_count_q;
        if (state_q != STATE_BUSY) begin
            timeout_count_d = '0;
        end else if (!completed && !decode_error) begin
            timeout_count_d = timeout_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin : timeout_reg
        if (i_rst) begin
            timeout_count_q <= '0;
        end else begin
            timeout_count_q <= timeout_count_d;
        end
    end

    assign timed_out = (timeout_count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin : fsm_next
        state_d          = state_q;
        req_write_d      = req_write_q;
        req_address_d    = req_address_q;
        req_write_data_d = req_write_data_q;
        req_strobe_d     = req_strobe_q;
        rsp_status_d     = rsp_status_q;
        rsp_read_data_d  = rsp_read_data_q;
        case (state_q)
            STATE_IDLE: begin
                if (i_cmd_valid) begin
                    req_write_d      = i_cmd_write;
                    req_address_d    = i_cmd_address;
                    req_write_data_d = i_cmd_write_data;
                    req_strobe_d     = i_cmd_write ? i_cmd_strobe : '1;
                    state_d          = STATE_BUSY;
                end
            end
            STATE_BUSY: begin
                // Register completion wins over a timeout expiring in the same cycle.
                if (decode_error) begin
                    rsp_status_d    = STATUS_DECODE_ERROR;
                    rsp_read_data_d = '0;
                    state_d         = STATE_RESPOND;
                end else if (completed) begin
                    rsp_status_d    = sel_status;
                    rsp_read_data_d = req_write_q ? '0 : sel_read_data;
                    state_d         = STATE_RESPOND;
                end else if (timed_out) begin
                    rsp_status_d    = STATUS_SLAVE_ERROR;
                    rsp_read_data_d = '0;
                    state_d         = STATE_RESPOND;
                end
            end
            STATE_RESPOND: begin
                if (i_rsp_ready) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin : fsm_reg
        if (i_rst) begin
            state_q          <= STATE_IDLE;
            req_write_q      <= 1'b0;
            req_address_q    <= '0;
            req_write_data_q <= '0;
            req_strobe_q     <= '0;
            rsp_status_q     <= '0;
            rsp_read_data_q  <= '0;
        end else begin
            state_q          <= state_d;
            req_write_q      <= req_write_d;
            req_address_q    <= req_address_d;
            req_write_data_q <= req_write_data_d;
            req_strobe_q     <= req_strobe_d;
            rsp_status_q     <= rsp_status_d;
            rsp_read_data_q  <= rsp_read_data_d;
        end
    end

    assign o_cmd_ready      = (state_q == STATE_IDLE);
    assign o_reg_valid      = (state_q == STATE_BUSY);
    assign o_rsp_valid      = (state_q == STATE_RESPOND);
    assign o_rsp_status     = rsp_status_q;
    assign o_rsp_read_data  = rsp_read_data_q;
    assign o_reg_access     = {1'b1, req_write_q};
    assign o_reg_address    = req_address_q;
    assign o_reg_write_data = req_write_data_q;
    assign o_reg_strobe     = req_strobe_q;

endmodule

// File: tb/tb_rggen_register_initiator.sv
// Randomized scoreboard bench for rggen_register_initiator; honours RGGEN_INITIATOR_TIMEOUT_EN.
module tb_rggen_register_initiator;

    localparam int unsigned AW   = 8;
    localparam int unsigned BW   = 32;
    localparam int unsigned NREG = 3;
    localparam int unsigned TMO  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_cmd_valid;
    logic                 o_cmd_ready;
    logic                 i_cmd_write;
    logic [AW-1:0]        i_cmd_address;
    logic [BW-1:0]        i_cmd_write_data;
    logic [BW-1:0]        i_cmd_strobe;
    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [1:0]           o_rsp_status;
    logic [BW-1:0]        o_rsp_read_data;
    logic                 o_reg_valid;
    logic [1:0]           o_reg_access;
    logic [AW-1:0]        o_reg_address;
    logic [BW-1:0]        o_reg_write_data;
    logic [BW-1:0]        o_reg_strobe;
    logic [NREG-1:0]      i_reg_active;
    logic [NREG-1:0]      i_reg_ready;
    logic [2*NREG-1:0]    i_reg_status;
    logic [BW*NREG-1:0]   i_reg_read_data;

    logic [1:0]           reg_st [NREG];
    logic [BW-1:0]        reg_rd [NREG];

    typedef struct packed {
        logic [1:0]    status;
        logic [BW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   in_rsp = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rggen_register_initiator #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .REGISTERS     (NREG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_write     (i_cmd_write),
        .i_cmd_address   (i_cmd_address),
        .i_cmd_write_data(i_cmd_write_data),
        .i_cmd_strobe    (i_cmd_strobe),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_status    (o_rsp_status),
        .o_rsp_read_data (o_rsp_read_data),
        .o_reg_valid     (o_reg_valid),
        .o_reg_access    (o_reg_access),
        .o_reg_address   (o_reg_address),
        .o_reg_write_data(o_reg_write_data),
        .o_reg_strobe    (o_reg_strobe),
        .i_reg_active    (i_reg_active),
        .i_reg_ready     (i_reg_ready),
        .i_reg_status    (i_reg_status),
        .i_reg_read_data (i_reg_read_data)
    );

    always_comb begin
        i_reg_status    = '0;
        i_reg_read_data = '0;
        for (int k = 0; k < int'(NREG); k++) begin
            i_reg_status[2*k +: 2]     = reg_st[k];
            i_reg_read_data[BW*k +: BW] = reg_rd[k];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Response monitor: pops on the first cycle of each response and checks it stays stable.
    always @(negedge clk) begin
        if (rst) begin
            in_rsp = 1'b0;
        end else if (o_rsp_valid) begin
            if (!in_rsp) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                end
                in_rsp = 1'b1;
            end
            check("rsp_status", 64'(o_rsp_status), 64'(cur.status));
            check("rsp_read_data", 64'(o_rsp_read_data), 64'(cur.data));
        end else begin
            in_rsp = 1'b0;
        end
    end

    task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                             input logic [BW-1:0] wd, input logic [BW-1:0] sb);
        int n = 0;
        i_cmd_valid      = 1'b1;
        i_cmd_write      = wr;
        i_cmd_address    = addr;
        i_cmd_write_data = wd;
        i_cmd_strobe     = sb;
        while (!o_cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("cmd_accept_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    // One complete transaction; registers raise ready from BUSY cycle index 'delay' onward.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                           input logic [BW-1:0] sb, input logic [NREG-1:0] act,
                           input logic [NREG-1:0] rdy, input int delay, input int hold);
        exp_t            e;
        int              exp_busy;
        int              busy;
        logic [NREG-1:0] h;
        h = act & rdy;
        e = '0;
        if (act == '0) begin
            e.status = 2'b11;
            exp_busy = 1;
        end else if (h == '0) begin
            e.status = 2'b10;
            exp_busy = int'(TMO);
        end else begin
            for (int k = 0; k < int'(NREG); k++) begin
                if (h[k]) begin
                    e.status = e.status | reg_st[k];
                    if (!wr) e.data = e.data | reg_rd[k];
                end
            end
            exp_busy = delay + 1;
        end
        exp_q.push_back(e);

        issue_cmd(wr, addr, wd, sb);
        i_reg_active = act;
        i_reg_ready  = '0;
        check("reg_access", 64'(o_reg_access), 64'({1'b1, wr}));
        check("reg_address", 64'(o_reg_address), 64'(addr));
        check("reg_strobe", 64'(o_reg_strobe), wr ? 64'(sb) : 64'(32'hFFFF_FFFF));
        if (wr) check("reg_write_data", 64'(o_reg_write_data), 64'(wd));
        busy = 0;
        while (!o_rsp_valid && busy < 200) begin
            if (!o_reg_valid) check("reg_valid_busy", 64'(o_reg_valid), 64'(1));
            if (busy == delay) i_reg_ready = rdy;
            @(posedge clk); #1; busy++;
        end
        check("busy_cycles", 64'(busy), 64'(exp_busy));
        i_reg_active = '0;
        i_reg_ready  = '0;
        check("reg_valid_respond", 64'(o_reg_valid), 64'(0));

        for (int i = 0; i < hold; i++) begin
            i_cmd_valid   = 1'b1;
            i_cmd_address = AW'($urandom);
            check("cmd_ready_hold", 64'(o_cmd_ready), 64'(0));
            @(posedge clk); #1;
        end
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        check("rsp_valid_after", 64'(o_rsp_valid), 64'(0));
        check("cmd_ready_after", 64'(o_cmd_ready), 64'(1));
        check("reg_address_kept", 64'(o_reg_address), 64'(addr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [NREG-1:0] act, rdy;
        int              bad;
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_address = '0;
        i_cmd_write_data = '0; i_cmd_strobe = '0; i_rsp_ready = 1'b0;
        i_reg_active = '0; i_reg_ready = '0;
        for (int k = 0; k < int'(NREG); k++) begin reg_st[k] = 2'b00; reg_rd[k] = '0; end
        do_reset();

        check("rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
        check("rst_rsp_status", 64'(o_rsp_status), 64'(0));
        check("rst_rsp_data", 64'(o_rsp_read_data), 64'(0));
        check("rst_reg_valid", 64'(o_reg_valid), 64'(0));
        check("rst_reg_access", 64'(o_reg_access), 64'(2'b10));
        check("rst_reg_address", 64'(o_reg_address), 64'(0));
        check("rst_reg_wdata", 64'(o_reg_write_data), 64'(0));
        check("rst_reg_strobe", 64'(o_reg_strobe), 64'(0));

        reg_st[0] = 2'b00; reg_rd[0] = 32'hDEAD_BEEF;
        run_txn(1'b0, 8'h04, 32'h0, 32'h0, 3'b001, 3'b001, 2, 0);
        reg_st[1] = 2'b00; reg_rd[1] = 32'hCAFE_F00D;
        run_txn(1'b1, 8'h08, 32'h1234_5678, 32'h0000_FFFF, 3'b010, 3'b010, 0, 0);
        run_txn(1'b0, 8'h7C, 32'h0, 32'h0, 3'b000, 3'b000, 0, 0);
        reg_st[2] = 2'b00; reg_rd[2] = 32'h0BAD_F00D;
        run_txn(1'b0, 8'h20, 32'h0, 32'h0, 3'b100, 3'b100, 1, 4);
        reg_st[0] = 2'b10; reg_rd[0] = 32'h0000_00F0; reg_st[2] = 2'b00; reg_rd[2] = 32'h0000_0F00;
        run_txn(1'b0, 8'h30, 32'h0, 32'h0, 3'b111, 3'b101, 1, 1);

        // Reset in the second BUSY cycle drops the transaction silently.
        issue_cmd(1'b0, 8'h44, 32'h0, 32'h0);
        i_reg_active = 3'b001;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        i_reg_active = '0;
        check("midbusy_reg_valid", 64'(o_reg_valid), 64'(0));
        check("midbusy_cmd_ready", 64'(o_cmd_ready), 64'(1));
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_rsp_valid) bad++;
            @(posedge clk); #1;
        end
        check("midbusy_no_rsp", 64'(bad), 64'(0));

`ifdef RGGEN_INITIATOR_TIMEOUT_EN
        run_txn(1'b0, 8'h50, 32'h0, 32'h0, 3'b001, 3'b000, 0, 0);
        reg_st[1] = 2'b00; reg_rd[1] = 32'h5555_AAAA;
        run_txn(1'b0, 8'h54, 32'h0, 32'h0, 3'b010, 3'b010, int'(TMO) - 1, 0);
`else
        issue_cmd(1'b0, 8'h50, 32'h0, 32'h0);
        i_reg_active = 3'b001;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            if (o_rsp_valid || !o_reg_valid) bad++;
            @(posedge clk); #1;
        end
        check("busy_held_no_timeout", 64'(bad), 64'(0));
        i_reg_active = '0;
        do_reset();
`endif

        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < int'(NREG); k++) begin
                reg_st[k] = 2'($urandom_range(0, 3));
                reg_rd[k] = BW'($urandom);
            end
            act = NREG'($urandom_range(0, 7));
            rdy = NREG'($urandom_range(1, 7));
            if (act != '0 && (act & rdy) == '0) rdy = act;
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom), BW'($urandom),
                    act, rdy, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
